// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types for the two-channel arbiter request front end.
//   grant_t    : 2-bit one-hot grant from the round-robin arbiter
//   GNT_*      : grant encodings (00 none, 01 ch0, 10 ch1, 11 illegal)
//   os_state_t : output-stage state (register empty / register holding data)
// ---------------------------------------------------------------------------
package arb_pkg;

   typedef logic [1:0] grant_t;

   localparam grant_t GNT_NONE    = 2'b00;
   localparam grant_t GNT_CH0     = 2'b01;
   localparam grant_t GNT_CH1     = 2'b10;
   localparam grant_t GNT_ILLEGAL = 2'b11;

   typedef enum logic {
      OS_EMPTY = 1'b0,
      OS_FULL  = 1'b1
   } os_state_t;

endpackage

// File: rtl/arb_req_queue_if.sv
// ---------------------------------------------------------------------------
// arb_req_queue_if
// Bundles every handshake/bus signal of arb_req_queue.
//   in0_valid/in0_ready/in0_data : channel 0 producer handshake
//   in1_valid/in1_ready/in1_data : channel 1 producer handshake
//   req   : to arbiter, req[i] = channel i FIFO non-empty
//   grant : from arbiter, one-hot
//   out_valid/out_ready/out_data/out_src : registered output handshake
//   occ0/occ1 : per-channel FIFO occupancy (status)
// Modports: slave = the queue itself, master = whatever drives it.
// ---------------------------------------------------------------------------
interface arb_req_queue_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in0_valid;
   logic              in0_ready;
   logic [DATA_W-1:0] in0_data;
   logic              in1_valid;
   logic              in1_ready;
   logic [DATA_W-1:0] in1_data;
   logic [1:0]        req;
   logic [1:0]        grant;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic [CNT_W-1:0]  occ0;
   logic [CNT_W-1:0]  occ1;

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, grant, out_ready,
      output in0_ready, in1_ready, req, out_valid, out_data, out_src, occ0, occ1
   );

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, grant, out_ready,
      input  in0_ready, in1_ready, req, out_valid, out_data, out_src, occ0, occ1
   );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO used once per input channel.
//   clk, rst : clock, asynchronous active-low reset
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : write data
//   rdata    : current head entry, valid whenever !empty
//   occ      : number of stored entries, 0..DEPTH
//   full     : occ == DEPTH
//   empty    : occ == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_W-1:0]            wdata,
   output logic [DATA_W-1:0]            rdata,
   output logic [$clog2(DEPTH):0]       occ,
   output logic                         full,
   output logic                         empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wrPtr_q;
   logic [ADDR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0]  occ_q;
   logic              pushEn;
   logic              popEn;

   // Guard both operations locally so the count can never leave 0..DEPTH,
   // even if a caller forgets to check full/empty.
   assign full   = (occ_q == CNT_W'(DEPTH));
   assign empty  = (occ_q == '0);
   assign pushEn = push && !full;
   assign popEn  = pop && !empty;
   assign occ    = occ_q;
   assign rdata  = mem[rdPtr_q];

   // Storage array carries no reset; stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         mem[wrPtr_q] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
   // push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         occ_q   <= '0;
      end else begin
         if (pushEn) begin
            wrPtr_q <= wrPtr_q + ADDR_W'(1);
         end
         if (popEn) begin
            rdPtr_q <= rdPtr_q + ADDR_W'(1);
         end
         case ({pushEn, popEn})
            2'b10:   occ_q <= occ_q + CNT_W'(1);
            2'b01:   occ_q <= occ_q - CNT_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: rtl/arb_req_queue.sv
// ---------------------------------------------------------------------------
// arb_req_queue
// Two-channel request front end for a 2-requester round-robin arbiter.
// Each channel has its own FIFO; a non-empty FIFO raises its req bit, and a
// one-hot grant moves the granted FIFO head into a single registered output
// slot tagged with its source channel.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : arb_req_queue_if.slave (input handshakes, req/grant, output
//         handshake, occupancy status)
// ---------------------------------------------------------------------------
module arb_req_queue
   import arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   arb_req_queue_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              push0;
   logic              push1;
   logic              pop0;
   logic              pop1;
   logic              full0;
   logic              full1;
   logic              empty0;
   logic              empty1;
   logic [DATA_W-1:0] head0;
   logic [DATA_W-1:0] head1;
   logic [CNT_W-1:0]  occ0;
   logic [CNT_W-1:0]  occ1;

   grant_t            grantIn;
   logic              takeCh0;
   logic              takeCh1;
   logic              load;

   os_state_t         state_q;
   os_state_t         state_d;
   logic [DATA_W-1:0] outData_q;
   logic [DATA_W-1:0] outData_d;
   logic              outSrc_q;
   logic              outSrc_d;
   logic              err_q;
   logic              err_d;

   // Input side: ready reflects only the registered count, so a full FIFO
   // refuses a push even in a cycle where it is also being popped.
   assign bus.in0_ready = !full0;
   assign bus.in1_ready = !full1;
   assign push0         = bus.in0_valid && !full0;
   assign push1         = bus.in1_valid && !full1;

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push0),
      .pop   (pop0),
      .wdata (bus.in0_data),
      .rdata (head0),
      .occ   (occ0),
      .full  (full0),
      .empty (empty0)
   );

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push1),
      .pop   (pop1),
      .wdata (bus.in1_data),
      .rdata (head1),
      .occ   (occ1),
      .full  (full1),
      .empty (empty1)
   );

   // Grant decode: only a clean one-hot grant to a non-empty FIFO counts.
   // A stale grant to an empty FIFO, 00 and 11 all fall through to no pop.
   // The output slot can take a word when empty or when its current word is
   // leaving this same cycle.
   assign grantIn = bus.grant;
   assign takeCh0 = (grantIn == GNT_CH0) && !empty0;
   assign takeCh1 = (grantIn == GNT_CH1) && !empty1;
   assign load    = (takeCh0 || takeCh1) && ((state_q == OS_EMPTY) || bus.out_ready);
   assign pop0    = load && takeCh0;
   assign pop1    = load && takeCh1;

   assign bus.req       = {!empty1, !empty0};
   assign bus.occ0      = occ0;
   assign bus.occ1      = occ1;
   assign bus.out_valid = (state_q == OS_FULL);
   assign bus.out_data  = outData_q;
   assign bus.out_src   = outSrc_q;

   // Output stage next-state: a load always wins (back-to-back transfer when
   // out_ready is high); otherwise a completed handshake empties the slot.
   // Data and source only change on a load, so they stay stable under
   // backpressure. The illegal-grant flag is sticky until reset.
   always_comb begin
      state_d   = state_q;
      outData_d = outData_q;
      outSrc_d  = outSrc_q;
      err_d     = err_q;
      if (load) begin
         state_d   = OS_FULL;
         outData_d = takeCh1 ? head1 : head0;
         outSrc_d  = takeCh1;
      end else if ((state_q == OS_FULL) && bus.out_ready) begin
         state_d = OS_EMPTY;
      end
      if (grantIn == GNT_ILLEGAL) begin
         err_d = 1'b1;
      end
   end

   // Output register and status flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= OS_EMPTY;
         outData_q <= '0;
         outSrc_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         outData_q <= outData_d;
         outSrc_q  <= outSrc_d;
         err_q     <= err_d;
      end
   end

   // Once set, the illegal-grant flag stays set until reset.
   errStickyA : assert property (@(posedge clk) disable iff (!rst) err_q |=> err_q);

   // A stalled output word must not change until it is accepted.
   outHoldA : assert property (@(posedge clk) disable iff (!rst)
      (bus.out_valid && !bus.out_ready) |=>
         (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_src)));

endmodule

// File: tb/tb_arb_req_queue.sv
// ---------------------------------------------------------------------------
// tb_arb_req_queue
// Directed scenarios followed by random traffic. A behavioural model built
// from per-channel queues and an "output slot occupied" flag predicts every
// status output each cycle and pushes expected output words into a
// scoreboard; an independent monitor pops the scoreboard on each output
// handshake.
// ---------------------------------------------------------------------------
module tb_arb_req_queue;
   import arb_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic clk;
   logic rst;

   arb_req_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [DATA_W-1:0] q0 [$];
   logic [DATA_W-1:0] q1 [$];
   logic [DATA_W:0]   expQ [$];
   logic              outFull;
   logic              errModel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check goes through here.
   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Clear the model to its post-reset picture.
   task automatic modelReset();
      q0.delete();
      q1.delete();
      expQ.delete();
      outFull  = 1'b0;
      errModel = 1'b0;
   endtask

   // Status outputs as implied by the model contents before the next edge.
   task automatic checkOutput();
      compare("in0_ready", 32'(bus.in0_ready), 32'(q0.size() != DEPTH));
      compare("in1_ready", 32'(bus.in1_ready), 32'(q1.size() != DEPTH));
      compare("req",       32'(bus.req),       {30'd0, q1.size() != 0, q0.size() != 0});
      compare("occ0",      32'(bus.occ0),      32'(q0.size()));
      compare("occ1",      32'(bus.occ1),      32'(q1.size()));
      compare("out_valid", 32'(bus.out_valid), 32'(outFull));
      compare("err",       32'(dut.err_q),     32'(errModel));
   endtask

   // Advance the model across one clock edge using the inputs now applied.
   task automatic modelStep();
      int  g;
      bit  p0;
      bit  p1;
      p0 = bus.in0_valid && (q0.size() != DEPTH);
      p1 = bus.in1_valid && (q1.size() != DEPTH);
      g  = -1;
      if (bus.grant == GNT_CH0 && q0.size() != 0) g = 0;
      if (bus.grant == GNT_CH1 && q1.size() != 0) g = 1;
      if (g >= 0 && (!outFull || bus.out_ready)) begin
         if (g == 0) expQ.push_back({1'b0, q0.pop_front()});
         else        expQ.push_back({1'b1, q1.pop_front()});
         outFull = 1'b1;
      end else if (outFull && bus.out_ready) begin
         outFull = 1'b0;
      end
      if (p0) q0.push_back(bus.in0_data);
      if (p1) q1.push_back(bus.in1_data);
      if (bus.grant == GNT_ILLEGAL) errModel = 1'b1;
   endtask

   // One clock of stimulus. Entered and left just after a rising edge.
   task automatic applyStimulus(input bit v0, input logic [DATA_W-1:0] d0,
                                input bit v1, input logic [DATA_W-1:0] d1,
                                input grant_t g, input bit rdy);
      bus.in0_valid = v0;
      bus.in0_data  = d0;
      bus.in1_valid = v1;
      bus.in1_data  = d1;
      bus.grant     = g;
      bus.out_ready = rdy;
      @(negedge clk);
      checkOutput();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, GNT_NONE, 1);
   endtask

   // Reset must take effect without waiting for a clock edge.
   task automatic applyReset();
      rst = 1'b0;
      #1;
      compare("rst_req",       32'(bus.req),       32'd0);
      compare("rst_out_valid", 32'(bus.out_valid), 32'd0);
      compare("rst_occ0",      32'(bus.occ0),      32'd0);
      compare("rst_occ1",      32'(bus.occ1),      32'd0);
      compare("rst_in0_ready", 32'(bus.in0_ready), 32'd1);
      compare("rst_in1_ready", 32'(bus.in1_ready), 32'd1);
      compare("rst_out_data",  32'(bus.out_data),  32'd0);
      compare("rst_out_src",   32'(bus.out_src),   32'd0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Monitor: checks the output word whenever the DUT presents one, and
   // retires the scoreboard entry when downstream accepts it.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && bus.out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL out_word: got 0x%0h with no word expected at %0t", bus.out_data, $time);
            end else begin
               compare("out_data", 32'(bus.out_data), 32'(expQ[0][DATA_W-1:0]));
               compare("out_src",  32'(bus.out_src),  32'(expQ[0][DATA_W]));
               if (bus.out_ready) expQ.delete(0);
            end
         end
      end
   end

   initial begin
      rst           = 1'b0;
      bus.in0_valid = 1'b0;
      bus.in0_data  = '0;
      bus.in1_valid = 1'b0;
      bus.in1_data  = '0;
      bus.grant     = GNT_NONE;
      bus.out_ready = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      applyReset();

      // Stale grants to empty FIFOs: no pop, no error.
      applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH1, 1);

      // Single word through channel 0.
      applyStimulus(1, 8'hA5, 0, '0, GNT_NONE, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      idle(2);

      // Fill channel 1; the fifth push is refused. Then drain back-to-back.
      for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 8'(8'h10 + i), GNT_NONE, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, '0, GNT_CH1, 1);
      idle(2);

      // Backpressure with a persistent grant.
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h30 + i), 0, '0, GNT_NONE, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, '0, GNT_CH0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      idle(2);

      // Both channels loaded, alternating grants.
      applyStimulus(1, 8'h01, 1, 8'h81, GNT_NONE, 1);
      applyStimulus(1, 8'h02, 1, 8'h82, GNT_NONE, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH1, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH1, 1);
      idle(2);

      // Illegal grant with both FIFOs non-empty: no pop, sticky error.
      applyStimulus(1, 8'h44, 1, 8'hC4, GNT_NONE, 1);
      applyStimulus(0, '0, 0, '0, GNT_ILLEGAL, 1);
      applyStimulus(0, '0, 0, '0, GNT_ILLEGAL, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
      applyStimulus(0, '0, 0, '0, GNT_CH1, 1);
      idle(2);

      // Random traffic, with a reset dropped in mid-stream.
      for (int n = 0; n < 2000; n++) begin
         int     r;
         grant_t g;
         if (n == 1000) applyReset();
         r = $urandom_range(0, 15);
         if (r == 0)     g = GNT_ILLEGAL;
         else if (r < 4) g = GNT_NONE;
         else if (r < 10) g = GNT_CH0;
         else            g = GNT_CH1;
         applyStimulus($urandom_range(0, 9) < 6, 8'($urandom),
                       $urandom_range(0, 9) < 6, 8'($urandom),
                       g, $urandom_range(0, 9) < 7);
      end

      // Drain whatever is left.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, '0, 0, '0, GNT_CH0, 1);
         applyStimulus(0, '0, 0, '0, GNT_CH1, 1);
      end
      idle(2);
      compare("drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
